// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Drives NUM_DIGITS multiplexed hex digits onto a shared active-low
//   segment/dp bus. Each digit can be blanked, can show its decimal point, and
//   all digits share a PWM brightness setting. The block also holds a memory
//   address stepper. The stepper advances at a selectable speed, can be paused,
//   and accepts a synchronous load.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   digits         hex value per digit, digit i = digits[4i+3:4i]
//   dp_in          1 = light the decimal point of digit i
//   blank          1 = digit i stays dark
//   brightness     PWM duty level 0..7, on-time = (brightness+1)/8
//   speed          0 = slow (x16), 1 = mid (x4), 2 = fast (x1), 3 = pause
//   addr_load      synchronous load of addr from addr_load_val
//   addr_load_val  value loaded into addr
//   addr           current memory address
//   step           one-cycle pulse in the cycle addr auto-increments
//   anode          active-low digit enables
//   cathode        active-low segments {g,f,e,d,c,b,a}
//   dp             active-low decimal point
module seg_scan_display #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_HZ    = 1000,
  parameter int STEP_HZ    = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [2:0]              brightness,
  input  logic [1:0]              speed,
  input  logic                    addr_load,
  input  logic [ADDR_W-1:0]       addr_load_val,
  output logic [ADDR_W-1:0]       addr,
  output logic                    step,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp
);

  localparam int SCAN_DIV = CLK_FREQ / (SCAN_HZ * NUM_DIGITS);
  localparam int STEP_DIV = CLK_FREQ / STEP_HZ;
  localparam int SLOT_W   = $clog2(SCAN_DIV);
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int INT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {
    SPD_SLOW  = 2'd0,
    SPD_MID   = 2'd1,
    SPD_FAST  = 2'd2,
    SPD_PAUSE = 2'd3
  } speed_e;

  // Hex to active-low 7-segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scan: slot timer, digit index and PWM phase
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
      phase    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values of its neighbours.
      phase <= phase + 3'd1;
      if (slot_cnt >= SLOT_W'(SCAN_DIV - 1)) begin
        slot_cnt <= '0;
        idx      <= (idx >= IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: select the current digit, apply PWM and blanking, register
  // ---------------------------------------------------------------------------
  logic [3:0]            sel_val;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  lit;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [6:0]            cathode_d;
  logic                  dp_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    sel_val   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    anode_d   = '1;
    cathode_d = 7'h7F;
    dp_d      = 1'b1;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_val   = digits[4*i +: 4];
        sel_dp    = dp_in[i];
        sel_blank = blank[i];
      end
    end

    // brightness = 7 makes every phase qualify, so the digit is always on.
    lit = (phase <= brightness) && !sel_blank;

    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) anode_d[i] = 1'b0;
      end
      cathode_d = hex_to_seg(sel_val);
      dp_d      = ~sel_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode   <= '1;
      cathode <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      anode   <= anode_d;
      cathode <= cathode_d;
      dp      <= dp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Address stepper: prescaler -> interval counter -> addr
  // ---------------------------------------------------------------------------
  speed_e            speed_sel;
  speed_e            run_speed_q;  // last non-pause speed, detects real changes
  logic [3:0]        pre_cnt;
  logic [3:0]        pre_max;
  logic [INT_W-1:0]  int_cnt;
  logic              tick;
  logic              speed_chg;

  always_comb begin
    speed_sel = speed_e'(speed);
    case (speed_sel)
      SPD_SLOW: pre_max = 4'd15;
      SPD_MID:  pre_max = 4'd3;
      default:  pre_max = 4'd0;
    endcase
    // >= lets a switch to a faster speed tick at once instead of running past
    // the shorter terminal count.
    tick      = (speed_sel != SPD_PAUSE) && (pre_cnt >= pre_max);
    // Entering or leaving pause is not a change, so a resume keeps its counts.
    speed_chg = (speed_sel != SPD_PAUSE) && (speed_sel != run_speed_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_speed_q <= SPD_SLOW;
      pre_cnt     <= '0;
      int_cnt     <= '0;
      addr        <= '0;
      step        <= 1'b0;
    end else begin
      step <= 1'b0;
      if (speed_sel != SPD_PAUSE) run_speed_q <= speed_sel;

      if (addr_load) begin
        // A load wins over a step that is due in the same cycle.
        addr    <= addr_load_val;
        pre_cnt <= '0;
        int_cnt <= '0;
      end else if (speed_sel != SPD_PAUSE) begin
        if (tick || speed_chg) pre_cnt <= '0;
        else                   pre_cnt <= pre_cnt + 1'b1;

        if (tick) begin
          if (int_cnt >= INT_W'(STEP_DIV - 1)) begin
            int_cnt <= '0;
            addr    <= addr + 1'b1;
            step    <= 1'b1;
          end else begin
            int_cnt <= int_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
